// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES sequencer and its neighbours.
//   AES_BLK_W   : width of one AES block / round key
//   RK_IDX_W    : width of the round-key index presented to the key store
//   aes_state_e : sequencer FSM states
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int RK_IDX_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_state_e;

endpackage

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
// Iterative AES encryption sequencer. Owns the 128-bit state register,
// applies the initial AddRoundKey on acceptance, then drives an external
// single-round combinational core for NR rounds (one per cycle), fetching
// round keys by index from an external key store. The ciphertext is offered
// on a valid/ready output.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : plaintext handshake, in_pt = plaintext (byte 0 MSB)
//   rk_idx / rk         : round-key index out, round key back (same cycle)
//   core_din/kin/sel    : state, round key and final-round select to core
//   core_dout           : core result (combinational)
//   out_valid/out_ready : ciphertext handshake, out_ct = ciphertext
//   busy                : high while rounds are running
//
// Parameter NR: number of rounds (10, 12 or 14).
// ---------------------------------------------------------------------------
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_pt,
    output logic [RK_IDX_W-1:0]  rk_idx,
    input  logic [AES_BLK_W-1:0] rk,
    output logic [AES_BLK_W-1:0] core_din,
    output logic [AES_BLK_W-1:0] core_kin,
    output logic                 core_sel,
    input  logic [AES_BLK_W-1:0] core_dout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_ct,
    output logic                 busy
);

    localparam logic [RK_IDX_W-1:0] NR_IDX  = RK_IDX_W'(NR);
    localparam logic [RK_IDX_W-1:0] RND_ONE = RK_IDX_W'(1);

    aes_state_e           fsm_q,       fsm_d;
    logic [AES_BLK_W-1:0] state_q,     state_d;
    logic [RK_IDX_W-1:0]  rnd_q,       rnd_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q,      busy_d;
    logic                 last_round;

    assign last_round = (rnd_q == NR_IDX);

    // Output decode: depends only on the FSM state and registers, plus the
    // out_ready pass-through to in_ready while holding a finished block.
    always_comb begin
        in_ready = 1'b0;
        rk_idx   = '0;
        core_sel = 1'b0;
        case (fsm_q)
            IDLE:  in_ready = 1'b1;
            ROUND: begin
                rk_idx   = rnd_q;
                core_sel = last_round;
            end
            DONE:  in_ready = out_ready;
            default: ;
        endcase
    end

    assign core_din  = state_q;
    assign core_kin  = rk;
    assign out_ct    = state_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

    // Next-state logic. In IDLE and DONE rk_idx is 0, so rk is round key 0
    // and the initial AddRoundKey can be folded into the load.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rnd_d   = rnd_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = in_pt ^ rk;
                    rnd_d   = RND_ONE;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                state_d = core_dout;
                if (last_round) begin
                    fsm_d = DONE;
                end else begin
                    rnd_d = rnd_q + RND_ONE;
                end
            end
            DONE: begin
                // Holding the ciphertext: nothing changes until it is taken.
                // A waiting block is loaded on the same edge (no bubble).
                if (out_ready) begin
                    if (in_valid) begin
                        state_d = in_pt ^ rk;
                        rnd_d   = RND_ONE;
                        fsm_d   = ROUND;
                    end else begin
                        fsm_d = IDLE;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
        // Status outputs are registered copies of the next state.
        out_valid_d = (fsm_d == DONE);
        busy_d      = (fsm_d == ROUND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            rnd_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

endmodule
